// File: rtl/top_c0_rr_arbiter.sv
// top_c0_rr_arbiter
// Round-robin arbiter that time-shares one combinational top_c0 datapath
// between NUM_REQ requesters. The winner's operand is registered onto dp_i,
// held for SETTLE_CYCLES clocks, then dp_o is captured and returned with a
// one-cycle rsp_valid pulse to the granted requester.
//
// Handshake: req is a level that is sampled only in IDLE. gnt is one-hot and
// held from the grant edge until the DONE->IDLE edge. rsp_valid pulses for
// exactly one cycle on the granted bit, and rsp_data is valid in that cycle
// and holds its value until the next capture. Dropping req after the grant
// does not abort the transaction.
//
// Optional feature macro: TOP_C0_ARB_ZERO_IDLE_EN
//   defined   : dp_i is cleared on the DONE->IDLE edge (dp_i == 0 in IDLE)
//   undefined : dp_i keeps the last granted operand through IDLE
module top_c0_rr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int IN_W          = 14,
    parameter int OUT_W         = 12,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [OUT_W-1:0]        rsp_data,
    output logic                    busy,
    output logic [IN_W-1:0]         dp_i,
    input  logic [OUT_W-1:0]        dp_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);
    localparam logic [PW:0]   NUM_EXT  = (PW + 1)'(NUM_REQ);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [CW-1:0]      cnt;

    logic [PW-1:0]      pick;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;

    logic [IN_W-1:0]    operand [NUM_REQ];

    // Unpack the flat operand bus so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign operand[g] = req_data[g*IN_W +: IN_W];
    end

    // Rotating-priority search: first set req bit starting at ptr, wrapping.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        pick       = '0;
        pick_found = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= NUM_EXT) begin
                sum = sum - NUM_EXT;
            end
            idx = sum[PW-1:0];
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    assign pick_onehot = NUM_REQ'(1) << pick;
    assign busy        = (state != IDLE);

    // Transaction FSM: IDLE (arbitrate) -> SETTLE (hold dp_i) -> DONE (turnaround).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            dp_i      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_onehot;
                        win   <= pick;
                        dp_i  <= operand[pick];
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rsp_data  <= dp_o;
                        rsp_valid <= gnt;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= '0;
                    gnt       <= '0;
                    ptr       <= (win == PTR_LAST) ? '0 : win + 1'b1;
`ifdef TOP_C0_ARB_ZERO_IDLE_EN
                    dp_i      <= '0;
`endif
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_c0_rr_arbiter.sv
// Directed bench for top_c0_rr_arbiter. A stand-in for top_c0
// (o = i[11:0] ^ 12'h2AA) is modelled inline on each instance's dp_i/dp_o.
// One instance runs with SETTLE_CYCLES=1, a second with SETTLE_CYCLES=3.
module tb_top_c0_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IN_W    = 14;
  localparam int OUT_W   = 12;
  localparam int TIMEOUT_CYCLES = 2000;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;

  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*IN_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [OUT_W-1:0]        rsp_data;
  logic                    busy;
  logic [IN_W-1:0]         dp_i;
  logic [OUT_W-1:0]        dp_o;

  logic [NUM_REQ-1:0]      req3 = '0;
  logic [NUM_REQ*IN_W-1:0] req_data3 = '0;
  logic [NUM_REQ-1:0]      gnt3;
  logic [NUM_REQ-1:0]      rsp_valid3;
  logic [OUT_W-1:0]        rsp_data3;
  logic                    busy3;
  logic [IN_W-1:0]         dp_i3;
  logic [OUT_W-1:0]        dp_o3;

  int n_total = 0;
  int n_pass  = 0;
  bit done_flag = 1'b0;

  logic [3:0]  exp_g [5];
  logic [11:0] exp_d [5];
  logic [OUT_W-1:0] exp_q [$];

  // Clock
  always #5 clk = ~clk;

  // Stand-in top_c0 datapaths
  assign dp_o  = dp_i[11:0] ^ 12'h2AA;
  assign dp_o3 = dp_i3[11:0] ^ 12'h2AA;

  top_c0_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .dp_i(dp_i), .dp_o(dp_o)
  );

  top_c0_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_data(req_data3),
    .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
    .dp_i(dp_i3), .dp_o(dp_o3)
  );

  // Watchdog
  initial begin
    repeat (TIMEOUT_CYCLES) @(posedge clk);
    if (!done_flag) begin
      $error("FAIL timeout: bench did not finish within %0d cycles", TIMEOUT_CYCLES);
      $finish;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [OUT_W-1:0] exp_v;

    exp_g[0] = 4'b0001; exp_d[0] = 12'h2BB;
    exp_g[1] = 4'b0010; exp_d[1] = 12'h3FF;
    exp_g[2] = 4'b1000; exp_d[2] = 12'h816;
    exp_g[3] = 4'b0001; exp_d[3] = 12'h2BB;
    exp_g[4] = 4'b0010; exp_d[4] = 12'h3FF;

    // Reset state
    tick(2);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_data", rsp_data, 12'h000);
    check("rst_dp_i", dp_i, 14'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_busy3", busy3, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check("idle_no_req_gnt", gnt, 4'b0000);

    // Contention with req=1011 held, ptr starts at 0
    req_data[0*IN_W +: IN_W] = 14'h0011;
    req_data[1*IN_W +: IN_W] = 14'h0155;
    req_data[2*IN_W +: IN_W] = 14'h0000;
    req_data[3*IN_W +: IN_W] = 14'h3ABC;
    req = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("cont_gnt", gnt, exp_g[k]);
      check("cont_busy", busy, 1'b1);
      check("cont_rv_low", rsp_valid, 4'b0000);
      exp_q.push_back(exp_d[k]);
      tick(1);
      check("cont_rsp_valid", rsp_valid, exp_g[k]);
      exp_v = exp_q.pop_front();
      check("cont_rsp_data", rsp_data, exp_v);
      check("cont_gnt_held", gnt, exp_g[k]);
      if (k == 4) req = 4'b0000;
      tick(1);
      check("cont_gnt_off", gnt, 4'b0000);
      check("cont_rv_off", rsp_valid, 4'b0000);
      check("cont_busy_off", busy, 1'b0);
    end
    check("cont_queue_empty", exp_q.size(), 0);
    tick(1);
    check("cont_stays_idle", busy, 1'b0);

    // Single request to requester 2, operand 0 -> 2AA (ptr is now 2)
    req = 4'b0100;
    tick(1);
    check("single_gnt", gnt, 4'b0100);
    check("single_dp_i", dp_i, 14'h0000);
    req = 4'b0000;
    tick(1);
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_data", rsp_data, 12'h2AA);
    tick(1);
    check("single_gnt_off", gnt, 4'b0000);
    check("single_busy_off", busy, 1'b0);

    // Requester 1 with all-ones operand -> D55 (ptr is now 3, wraps to 1)
    req_data[1*IN_W +: IN_W] = 14'h3FFF;
    req = 4'b0010;
    tick(1);
    check("ones_gnt", gnt, 4'b0010);
    check("ones_dp_i", dp_i, 14'h3FFF);
    req = 4'b0000;
    tick(1);
    check("ones_rsp_valid", rsp_valid, 4'b0010);
    check("ones_rsp_data", rsp_data, 12'hD55);
    tick(2);
    check("rsp_data_hold", rsp_data, 12'hD55);
    check("hold_rv_low", rsp_valid, 4'b0000);

    // Drop req[3] mid-SETTLE and change its operand; result still returns
    req = 4'b1000;
    tick(1);
    check("drop_gnt", gnt, 4'b1000);
    req = 4'b0000;
    req_data[3*IN_W +: IN_W] = 14'h0000;
    tick(1);
    check("drop_rsp_valid", rsp_valid, 4'b1000);
    check("drop_rsp_data", rsp_data, 12'h816);
    check("drop_dp_i_captured", dp_i, 14'h3ABC);
    tick(1);
    check("drop_idle", busy, 1'b0);
    req = 4'b1001;
    tick(1);
    check("rot_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick(2);

    // Reset mid-SETTLE with gnt=0100 (ptr is now 1)
    req = 4'b0100;
    tick(1);
    check("pre_rst_gnt", gnt, 4'b0100);
    req = 4'b0110;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 4'b0000);
    check("async_rst_rsp_valid", rsp_valid, 4'b0000);
    check("async_rst_dp_i", dp_i, 14'h0000);
    check("async_rst_busy", busy, 1'b0);
    tick(1);
    check("in_rst_rsp_valid", rsp_valid, 4'b0000);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick(1);
    check("post_rst_rsp_valid", rsp_valid, 4'b0010);
    tick(1);

    // SETTLE_CYCLES=3 instance
    req_data3[0*IN_W +: IN_W] = 14'h1234;
    req3 = 4'b0001;
    tick(1);
    check("s3_gnt", gnt3, 4'b0001);
    check("s3_dp_i", dp_i3, 14'h1234);
    req3 = 4'b0000;
    tick(1);
    check("s3_rv_e1", rsp_valid3, 4'b0000);
    tick(1);
    check("s3_rv_e2", rsp_valid3, 4'b0000);
    check("s3_gnt_held", gnt3, 4'b0001);
    tick(1);
    check("s3_rv_e3", rsp_valid3, 4'b0001);
    check("s3_rsp_data", rsp_data3, 12'h09E);
    tick(1);
    check("s3_gnt_off", gnt3, 4'b0000);
    check("s3_rv_off", rsp_valid3, 4'b0000);
    check("s3_busy_off", busy3, 1'b0);
`ifdef TOP_C0_ARB_ZERO_IDLE_EN
    check("s3_idle_dp_i", dp_i3, 14'h0000);
`else
    check("s3_idle_dp_i", dp_i3, 14'h1234);
`endif

    done_flag = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    if (n_pass == n_total) $display("TEST PASSED");
    else $display("TEST FAILED");
    $finish;
  end

endmodule

// File: doc/top_c0_rr_arbiter.md
Name: top_c0_rr_arbiter

Overview:
- Round-robin arbiter that time-shares one combinational top_c0 datapath (14-bit i, 12-bit o) between NUM_REQ requesters.
- Each granted requester's 14-bit operand is registered onto the datapath input and held for SETTLE_CYCLES clocks. The 12-bit result is then captured and returned with a one-cycle valid pulse.
- Sits between the requesters and the top_c0 instance. The top_c0 instance is outside this block, connected through dp_i/dp_o.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IN_W, 14, datapath input width (matches top_c0.i)
- OUT_W, 12, datapath output width (matches top_c0.o)
- SETTLE_CYCLES, 1, clocks dp_i is held before dp_o is sampled (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level
- req_data  input  NUM_REQ*IN_W  operands, requester n at [n*IN_W +: IN_W]
- gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
- rsp_valid  output  NUM_REQ  one-cycle result pulse to the granted requester
- rsp_data  output  OUT_W  captured result, valid when any rsp_valid bit is high
- busy  output  1  high whenever state != IDLE
- dp_i  output  IN_W  registered drive to top_c0.i
- dp_o  input  OUT_W  result from top_c0.o

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, dp_i=0, busy=0, rr pointer=0, settle counter=0.
- States: IDLE, SETTLE, DONE.
- IDLE: req is sampled only in this state. If any bit is set, at the edge:
  - winner w = first set bit searching ptr, ptr+1, ... mod NUM_REQ
  - gnt<=onehot(w), dp_i<=req_data[w], cnt<=0, state<=SETTLE
  - If no req, stay in IDLE; outputs unchanged.
- SETTLE: cnt increments each edge. On the edge where cnt==SETTLE_CYCLES-1:
  - rsp_data<=dp_o, rsp_valid<=onehot(w), state<=DONE
- DONE (lasts exactly one cycle): at the edge, rsp_valid<=0, gnt<=0, ptr<=(w+1) mod NUM_REQ, state<=IDLE.
- Timing:
  - gnt is high for SETTLE_CYCLES+1 cycles.
  - rsp_valid rises SETTLE_CYCLES edges after the grant edge.
  - Back-to-back throughput is one transaction per SETTLE_CYCLES+2 cycles; the IDLE turnaround is mandatory.
- At most one gnt bit and at most one rsp_valid bit are ever high. rsp_valid is only ever high for the bit that is high in gnt.
- req_data[w] is captured once, at the grant edge. Later changes to it are ignored for the current transaction.
- If a requester drops req mid-transaction, the transaction is not aborted: rsp_valid still pulses.
- If a requester still holds req in IDLE after DONE, it is rearbitrated with rotated priority, so it cannot starve the others.
- ptr wraps from NUM_REQ-1 to 0.
- rsp_data holds its last captured value until the next capture.
- rst_n asserted in any state: all outputs return to reset values immediately, the in-flight transaction is discarded (no rsp_valid), and ptr=0.
- Counter width is $clog2(SETTLE_CYCLES+1). No arithmetic is performed on the data paths.

Optional Feature:
- Macro: TOP_C0_ARB_ZERO_IDLE_EN.
- Defined: dp_i<=0 on the DONE->IDLE edge, so dp_i is 0 whenever state is IDLE. This limits datapath toggling.
- Undefined: dp_i holds the last granted operand through IDLE.
- All other behaviour is identical either way.

Test Plan:
- Reset: assert rst_n low mid-SETTLE with gnt=4'b0100 -> in the same cycle gnt=0, rsp_valid=0, dp_i=0, busy=0. After release with req=4'b0110, first grant is 4'b0010 (ptr reset to 0).
- Single request, SETTLE_CYCLES=1, bench-instantiated top_c0 on dp_i/dp_o: req=4'b0100, req_data[2]=14'h0000 -> gnt=4'b0100 after edge 1, rsp_valid=4'b0100 with rsp_data=12'h2AA after edge 2, gnt=0 and busy=0 after edge 3.
- Same setup, req_data[1]=14'h3FFF -> rsp_data=12'hD55 on rsp_valid=4'b0010.
- Contention: req=4'b1011 held continuously -> grant sequence 0001, 0010, 1000, 0001, 0010. Grants never overlap; consecutive grant edges are 3 cycles apart.
- Drop and rotation: after a grant to requester 3, deassert req[3] during SETTLE -> rsp_valid[3] still pulses. Then req=4'b1001 -> next grant is 4'b0001.
- SETTLE_CYCLES=3: rsp_valid rises exactly 3 edges after the grant edge. With TOP_C0_ARB_ZERO_IDLE_EN defined, dp_i=0 in the IDLE cycle that follows; without it, dp_i keeps the operand.
